// File: rtl/idu_pkg.sv
// idu_pkg: shared definitions for the instruction decode stage.
//   - RV32 major opcode constants
//   - imm_type_t : which immediate format an opcode uses
//   - imm_gen()  : builds the 32-bit sign-extended immediate for a format
//   - XLEN_DEFAULT : default data/PC width
package idu_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_t;

   // 32-bit immediate; the caller sign-extends it to XLEN.
   function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_type_t t);
      logic [31:0] imm;
      case (t)
         IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm = {inst[31:12], 12'b0};
         IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/idu_scoreboard.sv
// idu_scoreboard: one pending bit per architectural register.
// A bit is set when the decode stage issues a writer of that register.
// It is cleared when the result is written back, or when the writer is
// killed in the output slot by a flush.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   set_en/set_idx      mark a register as having an outstanding write
//   clr_en/clr_idx      writeback retires a register (idx != 0 by caller)
//   kill_en/kill_idx    flushed writer will never retire
//   rs1_used/rs1, rs2_used/rs2, rd_wen/rd   sources/destination under decode
//   hazard              combinational: the instruction under decode must wait
// Macro IDU_WB_BYPASS_EN: a register retiring this cycle is seen as free.
module idu_scoreboard import idu_pkg::*; #(
   parameter int NR_REGS = 32,
   parameter int AW      = $clog2(NR_REGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_en,
   input  logic [AW-1:0] set_idx,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_idx,
   input  logic          kill_en,
   input  logic [AW-1:0] kill_idx,
   input  logic          rs1_used,
   input  logic [AW-1:0] rs1,
   input  logic          rs2_used,
   input  logic [AW-1:0] rs2,
   input  logic          rd_wen,
   input  logic [AW-1:0] rd,
   output logic          hazard
);

   logic [NR_REGS-1:0] pending;
   logic [NR_REGS-1:0] busy;

   always_comb begin
      busy = pending;
`ifdef IDU_WB_BYPASS_EN
      if (clr_en) busy[clr_idx] = 1'b0;
`endif
   end

   assign hazard = (rs1_used && busy[rs1]) ||
                   (rs2_used && busy[rs2]) ||
                   (rd_wen   && busy[rd]);

   // A set on the same index as a clear wins: the new writer is still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         for (int i = 0; i < NR_REGS; i++) begin
            if (set_en && set_idx == AW'(i))
               pending[i] <= 1'b1;
            else if ((clr_en && clr_idx == AW'(i)) || (kill_en && kill_idx == AW'(i)))
               pending[i] <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/idu_stage.sv
// idu_stage: pipelined RV32 decode stage with internal register file and
// a pending-write scoreboard that stalls RAW/WAW hazards.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_inst/in_pc   fetch side
//   flush                         kill the output slot
//   out_valid/out_ready + out_pc, out_inst, out_rs1_data, out_rs2_data,
//   out_rd, out_rd_wen, out_imm   execute side, one registered slot
//   wb_valid/wb_rd/wb_data        register writeback
//   hazard_stall                  in_valid held off by the scoreboard
// Optional macro IDU_WB_BYPASS_EN: forward the writeback of this cycle to
// the operands and to the hazard check.
//
// Handshake: a transfer happens on a clock edge where valid and ready are
// both high; valid never waits on ready, and the producer keeps its payload
// stable while valid && !ready.
module idu_stage import idu_pkg::*; #(
   parameter int XLEN    = XLEN_DEFAULT,
   parameter int NR_REGS = 32,
   localparam int AW     = $clog2(NR_REGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_inst,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [AW-1:0]   out_rd,
   output logic            out_rd_wen,
   output logic [XLEN-1:0] out_imm,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            hazard_stall
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [AW-1:0]   rs1, rs2, rd;
   logic            rs1_used, rs2_used, writes_rd, rd_wen;
   imm_type_t       imm_type;
   logic            hazard, accept, wb_we;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic [XLEN-1:0] regs [NR_REGS];

   assign opcode = in_inst[6:0];
   assign funct3 = in_inst[14:12];
   // Index fields are truncated to AW bits (RV32E folds x16..x31 onto x0..x15).
   assign rs1    = in_inst[15 +: AW];
   assign rs2    = in_inst[20 +: AW];
   assign rd     = in_inst[7 +: AW];

   always_comb begin
      rs1_used  = 1'b0;
      rs2_used  = 1'b0;
      writes_rd = 1'b0;
      imm_type  = IMM_NONE;
      case (opcode)
         LUI, AUIPC: begin writes_rd = 1'b1; imm_type = IMM_U; end
         JAL:        begin writes_rd = 1'b1; imm_type = IMM_J; end
         JALR:       begin rs1_used = 1'b1; writes_rd = 1'b1; imm_type = IMM_I; end
         BRANCH:     begin rs1_used = 1'b1; rs2_used = 1'b1; imm_type = IMM_B; end
         LOAD:       begin rs1_used = 1'b1; writes_rd = 1'b1; imm_type = IMM_I; end
         STORE:      begin rs1_used = 1'b1; rs2_used = 1'b1; imm_type = IMM_S; end
         OP_IMM:     begin rs1_used = 1'b1; writes_rd = 1'b1; imm_type = IMM_I; end
         OP:         begin rs1_used = 1'b1; rs2_used = 1'b1; writes_rd = 1'b1; end
         SYSTEM: begin
            // CSRRW/CSRRS/CSRRC read rs1; the immediate CSR forms do not.
            rs1_used  = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd3);
            writes_rd = (funct3 != 3'd0);
            imm_type  = IMM_I;
         end
         default: ;
      endcase
   end

   assign rd_wen = writes_rd && (rd != '0);
   assign wb_we  = wb_valid && (wb_rd != '0);

   always_comb begin
      rs1_data = (rs1 == '0) ? '0 : regs[rs1];
      rs2_data = (rs2 == '0) ? '0 : regs[rs2];
`ifdef IDU_WB_BYPASS_EN
      if (wb_we && wb_rd == rs1) rs1_data = wb_data;
      if (wb_we && wb_rd == rs2) rs2_data = wb_data;
`endif
   end

   idu_scoreboard #(.NR_REGS(NR_REGS), .AW(AW)) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (accept && rd_wen),
      .set_idx  (rd),
      .clr_en   (wb_we),
      .clr_idx  (wb_rd),
      .kill_en  (flush && out_valid && out_rd_wen),
      .kill_idx (out_rd),
      .rs1_used (rs1_used),
      .rs1      (rs1),
      .rs2_used (rs2_used),
      .rs2      (rs2),
      .rd_wen   (rd_wen),
      .rd       (rd),
      .hazard   (hazard)
   );

   assign in_ready     = (!out_valid || out_ready) && !hazard && !flush;
   assign accept       = in_valid && in_ready;
   assign hazard_stall = in_valid && hazard;

   // x0 is reset to zero and never written, so it always reads zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NR_REGS; i++) regs[i] <= '0;
      end else if (wb_we) begin
         regs[wb_rd] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_inst     <= '0;
         out_rs1_data <= '0;
         out_rs2_data <= '0;
         out_rd       <= '0;
         out_rd_wen   <= 1'b0;
         out_imm      <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         out_pc       <= in_pc;
         out_inst     <= in_inst;
         out_rs1_data <= rs1_data;
         out_rs2_data <= rs2_data;
         out_rd       <= rd;
         out_rd_wen   <= rd_wen;
         out_imm      <= XLEN'($signed(imm_gen(in_inst, imm_type)));
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_idu_stage.sv
// tb_idu_stage: directed and randomized checks of idu_stage against a
// behavioural model (architectural register values, per-register
// outstanding-write flags and a one-entry output slot). A second instance
// built with NR_REGS=16 covers index truncation.
module tb_idu_stage;

   localparam int XLEN = 32;
   localparam int NR   = 32;
   localparam int AW   = 5;
`ifdef IDU_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst = 1'b1;
   logic            in_valid = 1'b0, in_ready;
   logic [31:0]     in_inst = '0;
   logic [XLEN-1:0] in_pc = '0;
   logic            flush = 1'b0;
   logic            out_valid, out_ready = 1'b0;
   logic [XLEN-1:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
   logic [31:0]     out_inst;
   logic [AW-1:0]   out_rd;
   logic            out_rd_wen;
   logic            wb_valid = 1'b0;
   logic [AW-1:0]   wb_rd = '0;
   logic [XLEN-1:0] wb_data = '0;
   logic            hazard_stall;

   idu_stage #(.XLEN(XLEN), .NR_REGS(NR)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rd(out_rd),
      .out_rd_wen(out_rd_wen), .out_imm(out_imm), .wb_valid(wb_valid),
      .wb_rd(wb_rd), .wb_data(wb_data), .hazard_stall(hazard_stall)
   );

   // RV32E-sized instance
   logic            s_rst = 1'b1, s_in_valid = 1'b0, s_in_ready, s_flush = 1'b0;
   logic [31:0]     s_in_inst = '0, s_out_inst;
   logic [XLEN-1:0] s_in_pc = '0, s_out_pc, s_out_rs1_data, s_out_rs2_data, s_out_imm;
   logic            s_out_valid, s_out_ready = 1'b0, s_out_rd_wen, s_hazard_stall;
   logic [3:0]      s_out_rd, s_wb_rd = '0;
   logic            s_wb_valid = 1'b0;
   logic [XLEN-1:0] s_wb_data = '0;

   idu_stage #(.XLEN(XLEN), .NR_REGS(16)) dut16 (
      .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_inst(s_in_inst), .in_pc(s_in_pc), .flush(s_flush), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_pc(s_out_pc), .out_inst(s_out_inst),
      .out_rs1_data(s_out_rs1_data), .out_rs2_data(s_out_rs2_data), .out_rd(s_out_rd),
      .out_rd_wen(s_out_rd_wen), .out_imm(s_out_imm), .wb_valid(s_wb_valid),
      .wb_rd(s_wb_rd), .wb_data(s_wb_data), .hazard_stall(s_hazard_stall)
   );

   // ---------------- scoreboard / model ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      bit          u1, u2, wen;
      int          rs1, rs2, rd;
      logic [31:0] imm;
   } dec_t;

   logic [31:0]   mreg [NR];
   bit            mpend [NR];
   bit            m_valid, m_wen;
   logic [31:0]   m_pc, m_inst, m_op1, m_op2, m_imm;
   int            m_rd;
   logic [AW-1:0] exp_q [$];   // registers handed to execute, awaiting writeback

   logic [6:0] opc_tab [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                                7'h23, 7'h13, 7'h33, 7'h73, 7'h0b};

   function automatic logic [31:0] imm_i(input logic [31:0] i);
      return $signed(i) >>> 20;
   endfunction

   function automatic dec_t decode(input logic [31:0] i);
      dec_t d;
      int   f3, v;
      d.u1 = 0; d.u2 = 0; d.wen = 0; d.imm = '0;
      d.rs1 = int'(i[19:15]); d.rs2 = int'(i[24:20]); d.rd = int'(i[11:7]);
      f3 = int'(i[14:12]);
      case (i[6:0])
         7'h37, 7'h17: begin d.wen = 1; d.imm = i & 32'hffff_f000; end
         7'h6f: begin
            d.wen = 1;
            v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            d.imm = v;
         end
         7'h67, 7'h03, 7'h13: begin d.u1 = 1; d.wen = 1; d.imm = imm_i(i); end
         7'h63: begin
            d.u1 = 1; d.u2 = 1;
            v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            d.imm = v;
         end
         7'h23: begin
            d.u1 = 1; d.u2 = 1;
            v = (i[31] ? -2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:7]);
            d.imm = v;
         end
         7'h33: begin d.u1 = 1; d.u2 = 1; d.wen = 1; end
         7'h73: begin d.u1 = (f3 >= 1 && f3 <= 3); d.wen = (f3 != 0); d.imm = imm_i(i); end
         default: ;
      endcase
      d.wen = d.wen && (d.rd != 0);
      return d;
   endfunction

   function automatic bit wb_hits(input int r);
      return wb_valid && (r != 0) && (int'(wb_rd) == r);
   endfunction

   function automatic bit busy(input int r);
      return (r != 0) && mpend[r] && !(BYP && wb_hits(r));
   endfunction

   function automatic logic [31:0] model_read(input int r);
      if (r == 0) return '0;
      if (BYP && wb_hits(r)) return wb_data;
      return mreg[r];
   endfunction

   // One clock of the main DUT: check combinational handshake, advance the
   // model on the edge, then check the registered slot.
   task automatic tick();
      dec_t        d;
      bit          haz, rdy, acc, handoff;
      logic [31:0] op1, op2;
      #1;
      d   = decode(in_inst);
      haz = (d.u1 && busy(d.rs1)) || (d.u2 && busy(d.rs2)) || (d.wen && busy(d.rd));
      rdy = (!m_valid || out_ready) && !haz && !flush;
      acc = in_valid && rdy && !rst;
      if (!rst) begin
         chk("in_ready", in_ready, rdy);
         chk("hazard_stall", hazard_stall, in_valid && haz);
      end
      op1 = model_read(d.rs1);
      op2 = model_read(d.rs2);
      handoff = m_valid && out_ready && !flush && !rst;
      @(posedge clk);
      if (rst) begin
         for (int r = 0; r < NR; r++) begin mreg[r] = '0; mpend[r] = 0; end
         m_valid = 0; m_wen = 0; m_pc = '0; m_inst = '0;
         m_op1 = '0; m_op2 = '0; m_imm = '0; m_rd = 0;
         exp_q.delete();
      end else begin
         if (handoff && m_wen) exp_q.push_back(AW'(m_rd));
         if (wb_valid && wb_rd != '0) begin mreg[wb_rd] = wb_data; mpend[wb_rd] = 0; end
         if (flush && m_valid && m_wen) mpend[m_rd] = 0;
         if (acc && d.wen) mpend[d.rd] = 1;
         if (flush) m_valid = 0;
         else if (acc) begin
            m_valid = 1; m_pc = in_pc; m_inst = in_inst; m_op1 = op1; m_op2 = op2;
            m_rd = d.rd; m_wen = d.wen; m_imm = d.imm;
         end else if (out_ready) m_valid = 0;
      end
      #1;
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
         chk("out_pc", out_pc, m_pc);
         chk("out_inst", out_inst, m_inst);
         chk("out_rs1_data", out_rs1_data, m_op1);
         chk("out_rs2_data", out_rs2_data, m_op2);
         chk("out_rd", out_rd, m_rd);
         chk("out_rd_wen", out_rd_wen, m_wen);
         chk("out_imm", out_imm, m_imm);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] w;

      // reset
      rst = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_inst", out_inst, 0);
      chk("rst_out_rs1", out_rs1_data, 0);
      chk("rst_out_rs2", out_rs2_data, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_out_rd_wen", out_rd_wen, 0);
      chk("rst_out_imm", out_imm, 0);

      // addi x1,x0,5
      rst = 1'b0; in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h1000; out_ready = 1'b1;
      tick();
      chk("addi_valid", out_valid, 1);
      chk("addi_rd", out_rd, 1);
      chk("addi_imm", out_imm, 5);
      chk("addi_rd_wen", out_rd_wen, 1);

      // add x2,x1,x1 blocked by outstanding x1
      in_inst = 32'h0010_8133; in_pc = 32'h1004;
      #1;
      chk("raw_stall", hazard_stall, 1);
      chk("raw_in_ready", in_ready, 0);
      tick();
      wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
`ifdef IDU_WB_BYPASS_EN
      #1;
      chk("bypass_in_ready", in_ready, 1);
      tick();
      wb_valid = 1'b0;
`else
      #1;
      chk("wb_cycle_in_ready", in_ready, 0);
      tick();
      wb_valid = 1'b0;
      #1;
      chk("after_wb_in_ready", in_ready, 1);
      tick();
`endif
      chk("raw_valid", out_valid, 1);
      chk("raw_rs1", out_rs1_data, 5);
      chk("raw_rs2", out_rs2_data, 5);

      // back-pressure: slot full, addi x5,x0,7 offered
      in_inst = 32'h0070_0293; in_pc = 32'h1008; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("hold_in_ready", in_ready, 0);
         tick();
         chk("hold_out_pc", out_pc, 32'h1004);
      end
      out_ready = 1'b1;
      tick();
      chk("release_out_pc", out_pc, 32'h1008);
      chk("release_out_rd", out_rd, 5);

      // flush a slot holding lui x3
      in_inst = 32'h1234_51b7; in_pc = 32'h100c;
      tick();
      chk("lui_imm", out_imm, 32'h1234_5000);
      in_valid = 1'b0; flush = 1'b1; out_ready = 1'b0;
      tick();
      chk("flush_valid", out_valid, 0);
      flush = 1'b0; in_valid = 1'b1; in_inst = 32'h0011_8213; in_pc = 32'h1010; out_ready = 1'b1;
      #1;
      chk("post_flush_stall", hazard_stall, 0);
      chk("post_flush_ready", in_ready, 1);
      tick();
      chk("post_flush_rd", out_rd, 4);

      // x0 writes are dropped, x0 never pending
      in_valid = 1'b0; wb_valid = 1'b1; wb_rd = '0; wb_data = 32'hdead_beef;
      tick();
      wb_valid = 1'b0; in_valid = 1'b1; in_inst = 32'h0010_0013; in_pc = 32'h1014;
      tick();
      chk("x0_rd_wen", out_rd_wen, 0);
      chk("x0_rs1", out_rs1_data, 0);
      in_inst = 32'h0000_0033; in_pc = 32'h1018;
      #1;
      chk("x0_no_stall", hazard_stall, 0);
      tick();
      chk("x0_read_rs2", out_rs2_data, 0);

      // randomized phase, with one reset in the middle
      in_valid = 1'b0; rst = 1'b1;
      tick();
      for (int c = 0; c < 500; c++) begin
         rst = (c == 250);
         in_valid = ($urandom_range(0, 3) != 0);
         w = $urandom;
         w[6:0]   = opc_tab[$urandom_range(0, 10)];
         w[11:7]  = 5'($urandom_range(0, 7));
         w[19:15] = 5'($urandom_range(0, 7));
         w[24:20] = 5'($urandom_range(0, 7));
         in_inst = w;
         in_pc = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 15) == 0);
         wb_valid = 1'b0; wb_rd = '0; wb_data = $urandom;
         if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            wb_valid = 1'b1; wb_rd = exp_q.pop_front();
         end else if ($urandom_range(0, 9) == 0) begin
            wb_valid = 1'b1; wb_rd = AW'($urandom_range(0, 7));
         end
         tick();
      end
      in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; rst = 1'b0;

      // NR_REGS=16: index fields truncate to 4 bits
      s_rst = 1'b0; s_out_ready = 1'b1;
      s_wb_valid = 1'b1; s_wb_rd = 4'd15; s_wb_data = 32'ha5a5_a5a5;
      @(posedge clk); #1;
      s_wb_rd = 4'd1; s_wb_data = 32'h0000_0011;
      @(posedge clk); #1;
      s_wb_valid = 1'b0; s_in_valid = 1'b1;
      s_in_inst = 32'h00f8_8833; s_in_pc = 32'h2000;   // rs1 field 17, rs2 15, rd field 16
      #1;
      chk("e_no_stall", s_hazard_stall, 0);
      @(posedge clk); #1;
      chk("e_valid", s_out_valid, 1);
      chk("e_rs1_trunc", s_out_rs1_data, 32'h0000_0011);
      chk("e_rs2_x15", s_out_rs2_data, 32'ha5a5_a5a5);
      chk("e_rd_trunc", s_out_rd, 0);
      chk("e_rd_wen", s_out_rd_wen, 0);
      s_in_inst = 32'h0008_01b3; s_in_pc = 32'h2004;   // rs1 field 16 -> x0, rd x3
      @(posedge clk); #1;
      chk("e_x0_read", s_out_rs1_data, 0);
      chk("e_rd3", s_out_rd, 3);
      chk("e_rd3_wen", s_out_rd_wen, 1);
      s_in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
